// File: rtl/p3_input_conditioner.sv
// Push-button conditioner for the p3 sequencer input: two-flop synchroniser,
// debounce counter, and a press/auto-repeat FSM producing registered pulses.
module p3_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_EN       = 1,
  parameter int unsigned REPEAT_DELAY    = 6,
  parameter int unsigned REPEAT_PERIOD   = 3
) (
  input  logic clock,
  input  logic RST,
  input  logic btn_in,
  output logic p_level,
  output logic p_rise,
  output logic p_fall,
  output logic p_step,
  output logic bouncing
);

  localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  localparam logic [CW-1:0] C_DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] C_DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] C_PER_LAST   = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HELD_DELAY  = 2'd1,
    HELD_REPEAT = 2'd2
  } state_t;

  logic          r_s1, r_s2;
  logic [CW-1:0] r_cnt;
  logic          r_level, r_rise, r_fall, r_step, r_bouncing;
  logic [RW-1:0] r_rcnt;
  state_t        r_state;

  logic          w_mismatch, w_toggle, w_rise_ev, w_fall_ev;
  logic [CW-1:0] w_cnt_nxt;
  logic [RW-1:0] w_rcnt_nxt;
  state_t        w_state_nxt;
  logic          w_step_nxt;

  always_comb begin
    w_mismatch = (r_s2 != r_level);
    w_toggle   = w_mismatch && (r_cnt == C_DB_LAST);
    w_rise_ev  = w_toggle && !r_level;
    w_fall_ev  = w_toggle && r_level;
    w_cnt_nxt  = (!w_mismatch || w_toggle) ? '0 : r_cnt + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!RST) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_cnt      <= '0;
      r_level    <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_bouncing <= 1'b0;
    end else begin
      r_s1       <= btn_in;
      r_s2       <= r_s1;
      r_cnt      <= w_cnt_nxt;
      r_bouncing <= (w_cnt_nxt != '0);
      if (w_toggle) r_level <= ~r_level;
      r_rise     <= w_rise_ev;
      r_fall     <= w_fall_ev;
    end
  end

  // State register; p_step is registered alongside so it aligns with p_rise.
  always_ff @(posedge clock) begin
    if (!RST) begin
      r_state <= IDLE;
      r_rcnt  <= '0;
      r_step  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_step  <= w_step_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt;
    case (r_state)
      IDLE: begin
        w_rcnt_nxt = '0;
        if (w_rise_ev) w_state_nxt = (REPEAT_EN != 0) ? HELD_DELAY : HELD_REPEAT;
      end
      HELD_DELAY: begin
        if (w_fall_ev) begin
          w_state_nxt = IDLE;
          w_rcnt_nxt  = '0;
        end else if (r_rcnt == C_DELAY_LAST) begin
          w_state_nxt = HELD_REPEAT;
          w_rcnt_nxt  = '0;
        end else begin
          w_rcnt_nxt  = r_rcnt + 1'b1;
        end
      end
      HELD_REPEAT: begin
        if (w_fall_ev) begin
          w_state_nxt = IDLE;
          w_rcnt_nxt  = '0;
        end else if (REPEAT_EN == 0 || r_rcnt == C_PER_LAST) begin
          w_rcnt_nxt  = '0;
        end else begin
          w_rcnt_nxt  = r_rcnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_rcnt_nxt  = '0;
      end
    endcase
  end

  // Release has priority over a coincident repeat tick.
  always_comb begin
    w_step_nxt = 1'b0;
    case (r_state)
      IDLE:        w_step_nxt = w_rise_ev;
      HELD_DELAY:  w_step_nxt = !w_fall_ev && (r_rcnt == C_DELAY_LAST);
      HELD_REPEAT: w_step_nxt = (REPEAT_EN != 0) && !w_fall_ev && (r_rcnt == C_PER_LAST);
      default:     w_step_nxt = 1'b0;
    endcase
  end

  assign p_level  = r_level;
  assign p_rise   = r_rise;
  assign p_fall   = r_fall;
  assign p_step   = r_step;
  assign bouncing = r_bouncing;

endmodule

// File: tb/tb_p3_input_conditioner.sv
// Directed bench: a repeating instance and a REPEAT_EN=0 instance share clock,
// reset and button; outputs are sampled 1ns after each rising edge.
module tb_p3_input_conditioner;

  logic clock = 1'b0;
  logic RST, btn_in;
  logic lvl_a, rise_a, fall_a, step_a, bnc_a;
  logic lvl_b, rise_b, fall_b, step_b, bnc_b;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  p3_input_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(6), .REPEAT_PERIOD(3)) u_dut_a (
    .clock(clock), .RST(RST), .btn_in(btn_in), .p_level(lvl_a), .p_rise(rise_a),
    .p_fall(fall_a), .p_step(step_a), .bouncing(bnc_a));

  p3_input_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(6), .REPEAT_PERIOD(3)) u_dut_b (
    .clock(clock), .RST(RST), .btn_in(btn_in), .p_level(lvl_b), .p_rise(rise_b),
    .p_fall(fall_b), .p_step(step_b), .bouncing(bnc_b));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int steps_b;
    logic seen_bnc, seen_lvl, seen_rise, seen_step;

    RST = 1'b0;
    btn_in = 1'b1;
    #1;
    tick(); tick();
    chk("rst_level", lvl_a, 0);
    chk("rst_rise",  rise_a, 0);
    chk("rst_fall",  fall_a, 0);
    chk("rst_step",  step_a, 0);
    chk("rst_bnc",   bnc_a, 0);
    chk("rst_b_level", lvl_b, 0);

    // First press: p_rise/p_step on the 6th edge with RST=1
    RST = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("press_rise",  rise_a, (k == 6));
      chk("press_level", lvl_a,  (k == 6));
      chk("press_bnc",   bnc_a,  (k >= 3 && k <= 5));
    end
    chk("press_step",   step_a, 1);
    chk("press_b_rise", rise_b, 1);
    chk("press_b_step", step_b, 1);
    steps_b = 1;

    // Hold: dut A steps at E+6 then every 3; dut B steps only at E
    for (int off = 1; off <= 30; off++) begin
      tick();
      chk("hold_step_a", step_a, (off >= 6 && ((off - 6) % 3) == 0));
      chk("hold_rise_a", rise_a, 0);
      if (step_b) steps_b++;
    end
    chk("hold_b_level", lvl_b, 1);

    // Release at E+30: fall lands on E+36, which would also be a repeat tick
    btn_in = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      tick();
      chk("rel_fall_a",  fall_a, (j == 6));
      chk("rel_level_a", lvl_a,  (j != 6));
      chk("rel_step_a",  step_a, (j == 3));
      chk("rel_fall_b",  fall_b, (j == 6));
      if (step_b) steps_b++;
    end
    chk("b_total_steps", steps_b, 1);
    tick();
    chk("rel_fall_a_once", fall_a, 0);
    chk("rel_step_after",  step_a, 0);

    // Glitch of 3 cycles
    repeat (3) tick();
    btn_in = 1'b1;
    repeat (3) tick();
    btn_in = 1'b0;
    seen_bnc = 0; seen_lvl = 0; seen_rise = 0; seen_step = 0;
    for (int j = 0; j < 10; j++) begin
      tick();
      seen_bnc  |= bnc_a;
      seen_lvl  |= lvl_a;
      seen_rise |= rise_a;
      seen_step |= step_a;
    end
    chk("glitch_bnc_seen", seen_bnc, 1);
    chk("glitch_level",    seen_lvl, 0);
    chk("glitch_rise",     seen_rise, 0);
    chk("glitch_step",     seen_step, 0);
    chk("glitch_bnc_end",  bnc_a, 0);

    // Second press repeats first-press timing
    btn_in = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("press2_rise", rise_a, (k == 6));
      chk("press2_step", step_a, (k == 6));
    end
    repeat (10) tick();

    // Reset mid-hold (HELD_REPEAT) with button still held
    RST = 1'b0;
    tick();
    RST = 1'b1;
    chk("mid_rst_level", lvl_a, 0);
    chk("mid_rst_fall",  fall_a, 0);
    chk("mid_rst_step",  step_a, 0);
    chk("mid_rst_rise",  rise_a, 0);
    chk("mid_rst_bnc",   bnc_a, 0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("post_rst_fall", fall_a, 0);
      chk("post_rst_rise", rise_a, (k == 6));
      chk("post_rst_step", step_a, (k == 6));
    end
    tick();
    chk("post_rst_rise_once", rise_a, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
